// File: rtl/ffstdp_update_engine_if.sv
// Bus bundle between the FF-STDP update engine, the neuron controller,
// the derivative-LUT loader and the synapse / pre-count memories.
//
// Handshake rules: start is a single-cycle request with no ready. It is
// taken only while the engine is idle; a start seen at any other time is
// dropped. is_pos, is_train and post_spike_cnt are sampled in the same cycle
// as start. sram_rdata and pre_cnt_rdata must hold the data for sram_raddr
// in the cycle after sram_re is high. sram_we is a fire-and-forget write with
// no acceptance signal. done pulses for one cycle at the end of every
// accepted run. busy is high while the weight walk is in flight.
interface ffstdp_update_engine_if #(
   parameter int WEIGHT_WIDTH   = 8,
   parameter int PRE_CNT_WIDTH  = 5,
   parameter int POST_CNT_WIDTH = 7,
   parameter int LUT_DEPTH      = 32,
   parameter int NUM_SYN        = 256
);
   localparam int LUT_AW = $clog2(LUT_DEPTH);
   localparam int ADDR_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;

   // run request from the neuron controller
   logic                      start;
   logic                      is_pos;
   logic                      is_train;
   logic [POST_CNT_WIDTH-1:0] post_spike_cnt;

   // derivative LUT load port
   logic                      lut_we;
   logic                      lut_sel;
   logic [LUT_AW-1:0]         lut_addr;
   logic [WEIGHT_WIDTH-1:0]   lut_data;

   // synapse SRAM and pre-spike-count memory
   logic                      sram_re;
   logic [ADDR_W-1:0]         sram_raddr;
   logic [WEIGHT_WIDTH-1:0]   sram_rdata;
   logic [PRE_CNT_WIDTH-1:0]  pre_cnt_rdata;
   logic                      sram_we;
   logic [ADDR_W-1:0]         sram_waddr;
   logic [WEIGHT_WIDTH-1:0]   sram_wdata;

   // status
   logic                      busy;
   logic                      done;
   logic [15:0]               sat_cnt;

   modport master (
      output start, is_pos, is_train, post_spike_cnt,
      output lut_we, lut_sel, lut_addr, lut_data,
      output sram_rdata, pre_cnt_rdata,
      input  sram_re, sram_raddr, sram_we, sram_waddr, sram_wdata,
      input  busy, done, sat_cnt
   );

   modport slave (
      input  start, is_pos, is_train, post_spike_cnt,
      input  lut_we, lut_sel, lut_addr, lut_data,
      input  sram_rdata, pre_cnt_rdata,
      output sram_re, sram_raddr, sram_we, sram_waddr, sram_wdata,
      output busy, done, sat_cnt
   );
endinterface

// File: rtl/ffstdp_update_engine.sv
// Forward-Forward STDP weight-update engine. One accepted training event
// walks every synapse of a post-neuron: read weight and pre-spike count,
// scale the latched LUT derivative by the pre count, shift by the learning
// rate and write back a saturated weight. Two pipeline stages sit between
// the read and the write (memory latency, then product register).
module ffstdp_update_engine #(
   parameter int WEIGHT_WIDTH   = 8,
   parameter int PRE_CNT_WIDTH  = 5,
   parameter int POST_CNT_WIDTH = 7,
   parameter int LUT_DEPTH      = 32,
   parameter int LR_SHIFT       = 6,
   parameter int NUM_SYN        = 256
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   ffstdp_update_engine_if.slave    bus,
   output logic [1:0]               o_dbg_state
);
   localparam int LUT_AW = $clog2(LUT_DEPTH);
   localparam int ADDR_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
   localparam int P_W    = WEIGHT_WIDTH + PRE_CNT_WIDTH;
   localparam int W_MAX  = (1 << (WEIGHT_WIDTH - 1)) - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next;

   // derivative tables, loaded at run time and never reset
   logic [WEIGHT_WIDTH-1:0]   r_lut_pos [LUT_DEPTH];
   logic [WEIGHT_WIDTH-1:0]   r_lut_neg [LUT_DEPTH];

   // run parameters latched at accept
   logic [WEIGHT_WIDTH-1:0]   r_d;
   logic                      r_is_pos;
   logic                      r_is_train;
   logic [ADDR_W-1:0]         r_k;

   // pipeline: read-valid stage (memory latency) and product stage
   logic                      r_rd_vld;
   logic [ADDR_W-1:0]         r_rd_addr;
   logic                      r_s1_vld;
   logic [ADDR_W-1:0]         r_s1_addr;
   logic [P_W-1:0]            r_p;
   logic [WEIGHT_WIDTH-1:0]   r_w;
   logic [15:0]               r_sat_cnt;

   logic                      w_accept;
   logic                      w_last_rd;
   logic                      w_busy;
   logic                      w_done;
   logic                      w_re;
   logic [LUT_AW-1:0]         w_lut_idx;
   logic [WEIGHT_WIDTH-1:0]   w_lut_d;
   logic [P_W-1:0]            w_prod;
   logic [P_W-1:0]            w_shift;
   logic                      w_mag_clamp;
   logic [WEIGHT_WIDTH-1:0]   w_mag;
   logic [WEIGHT_WIDTH:0]     w_delta;
   logic [WEIGHT_WIDTH:0]     w_sum;
   logic                      w_pos_ovf;
   logic                      w_neg_ovf;
   logic [WEIGHT_WIDTH-1:0]   w_wnew;
   logic                      w_sat;

   assign w_accept  = (r_state == S_IDLE) && bus.start;
   assign w_last_rd = (r_state == S_RUN) && (r_k == ADDR_W'(NUM_SYN - 1));

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // FSM next state: drain ends once the last product has been written
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = bus.is_train ? S_RUN : S_DONE;
         S_RUN:   if (w_last_rd) w_next = S_DRAIN;
         S_DRAIN: if (r_s1_vld && !r_rd_vld) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      w_re   = 1'b0;
      case (r_state)
         S_RUN:   begin w_busy = 1'b1; w_re = r_is_train; end
         S_DRAIN: w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   // LUT load; blocked while a walk is in flight so the latched D stays coherent
   always_ff @(posedge i_clk) begin
      if (bus.lut_we && !w_busy) begin
         if (bus.lut_sel) r_lut_pos[bus.lut_addr] <= bus.lut_data;
         else             r_lut_neg[bus.lut_addr] <= bus.lut_data;
      end
   end

   // LUT lookup with the post count clamped to the last entry
   always_comb begin
      w_lut_idx = LUT_AW'(LUT_DEPTH - 1);
      if (32'(bus.post_spike_cnt) < LUT_DEPTH - 1)
         w_lut_idx = LUT_AW'(bus.post_spike_cnt);
      w_lut_d = bus.is_pos ? r_lut_pos[w_lut_idx] : r_lut_neg[w_lut_idx];
   end

   // Latch run parameters at accept and step the read address during RUN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_d        <= '0;
         r_is_pos   <= 1'b0;
         r_is_train <= 1'b0;
         r_k        <= '0;
      end else if (w_accept) begin
         r_d        <= w_lut_d;
         r_is_pos   <= bus.is_pos;
         r_is_train <= bus.is_train;
         r_k        <= '0;
      end else if (w_last_rd) begin
         r_k        <= '0;
      end else if (w_re) begin
         r_k        <= r_k + 1'b1;
      end
   end

   assign w_prod = {{PRE_CNT_WIDTH{1'b0}}, r_d} * {{WEIGHT_WIDTH{1'b0}}, bus.pre_cnt_rdata};

   // Pipeline: track read latency, then register product and old weight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_vld  <= 1'b0;
         r_rd_addr <= '0;
         r_s1_vld  <= 1'b0;
         r_s1_addr <= '0;
         r_p       <= '0;
         r_w       <= '0;
      end else begin
         r_rd_vld  <= w_re;
         r_rd_addr <= r_k;
         r_s1_vld  <= r_rd_vld;
         r_s1_addr <= r_rd_addr;
         if (r_rd_vld) begin
            r_p <= w_prod;
            r_w <= bus.sram_rdata;
         end
      end
   end

   // Write-back arithmetic: clamp the step, add at one extra bit, then saturate
   always_comb begin
      w_shift     = r_p >> LR_SHIFT;
      w_mag_clamp = (w_shift > P_W'(W_MAX));
      w_mag       = w_mag_clamp ? WEIGHT_WIDTH'(W_MAX) : w_shift[WEIGHT_WIDTH-1:0];
      w_delta     = r_is_pos ? {1'b0, w_mag} : -{1'b0, w_mag};
      w_sum       = {r_w[WEIGHT_WIDTH-1], r_w} + w_delta;
      w_pos_ovf   = ~w_sum[WEIGHT_WIDTH] &  w_sum[WEIGHT_WIDTH-1];
      w_neg_ovf   =  w_sum[WEIGHT_WIDTH] & ~w_sum[WEIGHT_WIDTH-1];
      w_wnew      = w_sum[WEIGHT_WIDTH-1:0];
      if (w_pos_ovf) w_wnew = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
      if (w_neg_ovf) w_wnew = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
      w_sat       = w_mag_clamp | w_pos_ovf | w_neg_ovf;
   end

   // Saturation counter: cleared on accept, one count per clamped write, sticky at max
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sat_cnt <= '0;
      end else if (w_accept) begin
         r_sat_cnt <= '0;
      end else if (r_s1_vld && w_sat && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign bus.sram_re    = w_re;
   assign bus.sram_raddr = r_k;
   assign bus.sram_we    = r_s1_vld & r_is_train;
   assign bus.sram_waddr = r_s1_addr;
   assign bus.sram_wdata = w_wnew;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.sat_cnt    = r_sat_cnt;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_ffstdp_update_engine.sv
// Bench for ffstdp_update_engine: a 256-synapse instance with the default
// learning-rate shift and a 1-synapse instance with no shift. Expected writes
// are queued when a run is launched and popped as the engine writes.
module tb_ffstdp_update_engine;
   localparam int WW    = 8;
   localparam int PCW   = 5;
   localparam int POSTW = 7;
   localparam int DEPTH = 32;
   localparam int NSYN  = 256;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   ffstdp_update_engine_if #(.NUM_SYN(NSYN)) bus ();
   ffstdp_update_engine_if #(.NUM_SYN(1))    bus1 ();
   logic [1:0] dbg0;
   logic [1:0] dbg1;

   ffstdp_update_engine #(.NUM_SYN(NSYN)) u_dut (
      .i_clk(clk), .i_rst(rst), .bus(bus), .o_dbg_state(dbg0)
   );
   ffstdp_update_engine #(.LR_SHIFT(0), .NUM_SYN(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .bus(bus1), .o_dbg_state(dbg1)
   );

   int mem_w   [NSYN];
   int mem_pre [NSYN];
   int lut_pos [DEPTH];
   int lut_neg [DEPTH];
   int w1 = 0;
   int p1 = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp1_q[$];
   int re_cnt   = 0;
   int we_cnt   = 0;
   int done_cnt = 0;

   // memory read models: one-cycle latency
   always @(posedge clk) begin
      if (bus.sram_re) begin
         bus.sram_rdata    <= WW'(mem_w[bus.sram_raddr]);
         bus.pre_cnt_rdata <= PCW'(mem_pre[bus.sram_raddr]);
      end
      if (bus1.sram_re) begin
         bus1.sram_rdata    <= WW'(w1);
         bus1.pre_cnt_rdata <= PCW'(p1);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard side: compare every write against the queue head
   always @(negedge clk) begin
      if (bus.sram_re === 1'b1) re_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.sram_we !== 1'b0) begin
         we_cnt++;
         if (exp_q.size() == 0)
            chk("wr_unexpected", {16'd0, bus.sram_waddr, bus.sram_wdata}, 32'hFFFF_FFFF);
         else
            chk("wr", {16'd0, bus.sram_waddr, bus.sram_wdata}, {16'd0, exp_q.pop_front()});
      end
      if (bus1.sram_we !== 1'b0) begin
         if (exp1_q.size() == 0)
            chk("n1_wr_unexpected", {23'd0, bus1.sram_waddr, bus1.sram_wdata}, 32'hFFFF_FFFF);
         else
            chk("n1_wr", {23'd0, bus1.sram_waddr, bus1.sram_wdata}, {16'd0, exp1_q.pop_front()});
      end
   end

   // reference update: returns {saturated, new weight}
   function automatic logic [8:0] model_upd(input int w, input int pre, input int d,
                                            input bit pos, input int sh);
      int p, m, s;
      bit sat;
      sat = 1'b0;
      p = d * pre;
      m = p >> sh;
      if (m > 127) begin m = 127; sat = 1'b1; end
      s = pos ? w + m : w - m;
      if (s > 127)  begin s = 127;  sat = 1'b1; end
      if (s < -128) begin s = -128; sat = 1'b1; end
      return {sat, s[7:0]};
   endfunction

   task automatic fill_const(input int w, input int pre);
      for (int k = 0; k < NSYN; k++) begin mem_w[k] = w; mem_pre[k] = pre; end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < NSYN; k++) begin
         mem_w[k]   = int'($urandom_range(0, 255)) - 128;
         mem_pre[k] = int'($urandom_range(0, 31));
      end
      mem_pre[0] = 0;
      mem_pre[1] = 31;
      mem_w[2]   = 127;
      mem_w[3]   = -128;
   endtask

   task automatic lut_wr(input bit sel, input int addr, input int data);
      bus.lut_we = 1'b1; bus.lut_sel = sel; bus.lut_addr = 5'(addr); bus.lut_data = 8'(data);
      @(negedge clk);
      bus.lut_we = 1'b0;
      if (sel) lut_pos[addr] = data; else lut_neg[addr] = data;
   endtask

   // queue expected writes for one run; returns expected saturation count
   task automatic push_exp(input bit pos, input int post, output int exp_sat, output int idx);
      int d;
      logic [8:0] r;
      idx = (post > DEPTH - 1) ? DEPTH - 1 : post;
      d = pos ? lut_pos[idx] : lut_neg[idx];
      exp_sat = 0;
      for (int k = 0; k < NSYN; k++) begin
         r = model_upd(mem_w[k], mem_pre[k], d, pos, 6);
         exp_q.push_back({8'(k), r[7:0]});
         exp_sat += int'(r[8]);
      end
   endtask

   // driver: launch a run, optionally disturb it, and check its completion
   task automatic run(input bit pos, input bit train, input int post, input bit noise,
                      input int same_lut);
      int idx, exp_sat, lat, busy_n, re0, we0, dn0;
      if (train) push_exp(pos, post, exp_sat, idx);
      else begin exp_sat = 0; idx = (post > DEPTH - 1) ? DEPTH - 1 : post; end
      re0 = re_cnt; we0 = we_cnt; dn0 = done_cnt;
      bus.start = 1'b1; bus.is_pos = pos; bus.is_train = train; bus.post_spike_cnt = POSTW'(post);
      if (same_lut >= 0) begin
         bus.lut_we = 1'b1; bus.lut_sel = pos; bus.lut_addr = 5'(idx); bus.lut_data = 8'(same_lut);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.lut_we = 1'b0;
      if (same_lut >= 0) begin
         if (pos) lut_pos[idx] = same_lut; else lut_neg[idx] = same_lut;
      end
      lat = 1; busy_n = 0;
      while (bus.done !== 1'b1 && lat < 600) begin
         if (bus.busy === 1'b1) busy_n++;
         if (noise && lat >= 5 && lat <= 10) begin
            bus.start = 1'b1; bus.is_pos = ~pos; bus.is_train = 1'b1; bus.post_spike_cnt = '0;
            bus.lut_we = 1'b1; bus.lut_sel = pos; bus.lut_addr = 5'(idx); bus.lut_data = 8'h00;
         end else begin
            bus.start = 1'b0; bus.lut_we = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0; bus.lut_we = 1'b0;
      chk("done_lat", lat, train ? NSYN + 3 : 1);
      chk("busy_cycles", busy_n, train ? NSYN + 2 : 0);
      chk("sat_cnt", {16'd0, bus.sat_cnt}, exp_sat);
      chk("wr_left", exp_q.size(), 0);
      @(negedge clk);
      chk("done_pulse", {31'd0, bus.done}, 0);
      chk("done_count", done_cnt - dn0, 1);
      chk("re_count", re_cnt - re0, train ? NSYN : 0);
      chk("we_count", we_cnt - we0, train ? NSYN : 0);
      chk("state_idle", {30'd0, dbg0}, 0);
   endtask

   // driver for the single-synapse, zero-shift instance
   task automatic run1(input int w, input int p, input bit pos, input int post, input int d);
      logic [8:0] r;
      int lat;
      r = model_upd(w, p, d, pos, 0);
      w1 = w; p1 = p;
      exp1_q.push_back({8'd0, r[7:0]});
      bus1.start = 1'b1; bus1.is_pos = pos; bus1.is_train = 1'b1; bus1.post_spike_cnt = POSTW'(post);
      @(negedge clk);
      bus1.start = 1'b0;
      lat = 1;
      while (bus1.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      chk("n1_done_lat", lat, 4);
      chk("n1_sat", {16'd0, bus1.sat_cnt}, {23'd0, r[8]});
      chk("n1_left", exp1_q.size(), 0);
      @(negedge clk);
      chk("n1_state", {30'd0, dbg1}, 0);
   endtask

   initial begin : stim
      int dn0, idx, exp_sat;
      bus.start = 0; bus.is_pos = 0; bus.is_train = 0; bus.post_spike_cnt = 0;
      bus.lut_we = 0; bus.lut_sel = 0; bus.lut_addr = 0; bus.lut_data = 0;
      bus1.start = 0; bus1.is_pos = 0; bus1.is_train = 0; bus1.post_spike_cnt = 0;
      bus1.lut_we = 0; bus1.lut_sel = 0; bus1.lut_addr = 0; bus1.lut_data = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_re",    {31'd0, bus.sram_re}, 0);
      chk("rst_we",    {31'd0, bus.sram_we}, 0);
      chk("rst_busy",  {31'd0, bus.busy}, 0);
      chk("rst_done",  {31'd0, bus.done}, 0);
      chk("rst_sat",   {16'd0, bus.sat_cnt}, 0);
      chk("rst_raddr", {24'd0, bus.sram_raddr}, 0);
      chk("rst_waddr", {24'd0, bus.sram_waddr}, 0);
      chk("rst_wdata", {24'd0, bus.sram_wdata}, 0);
      chk("rst_state", {30'd0, dbg0}, 0);

      // LUT load: random background, then the directed entries
      for (int i = 0; i < DEPTH; i++) begin
         lut_wr(1'b1, i, int'($urandom_range(1, 255)));
         lut_wr(1'b0, i, int'($urandom_range(1, 255)));
      end
      lut_wr(1'b1, 3, 8'h40);
      lut_wr(1'b0, 31, 8'hFF);
      lut_wr(1'b1, 31, 8'hFF);
      lut_wr(1'b1, 5, 8'h00);

      // nominal update: 10 + (64*16 >> 6) = 26
      fill_const(10, 16);
      run(1'b1, 1'b1, 3, 1'b0, -1);
      // negative saturation with post count clamped to the last entry
      fill_const(-120, 31);
      run(1'b0, 1'b1, 100, 1'b0, -1);
      // positive saturation
      fill_const(120, 31);
      run(1'b1, 1'b1, 31, 1'b0, -1);
      // D = 0 keeps every weight, writes still issued
      fill_rand();
      run(1'b1, 1'b1, 5, 1'b0, -1);
      // random patterns, both polarities
      fill_rand();
      run(1'b0, 1'b1, int'($urandom_range(0, 127)), 1'b0, -1);
      fill_rand();
      run(1'b1, 1'b1, int'($urandom_range(0, 30)), 1'b0, -1);
      // training disabled: immediate DONE, no memory traffic
      run(1'b1, 1'b0, 3, 1'b0, -1);
      // START and LUT_WE during the walk are ignored; rerun shows the LUT intact
      fill_const(10, 16);
      run(1'b1, 1'b1, 3, 1'b1, -1);
      run(1'b1, 1'b1, 3, 1'b0, -1);
      // LUT write in the accept cycle: this run uses 0x40, the next uses 0x20
      run(1'b1, 1'b1, 3, 1'b0, 8'h20);
      run(1'b1, 1'b1, 3, 1'b0, -1);

      // reset in the middle of a walk
      fill_rand();
      push_exp(1'b1, 7, exp_sat, idx);
      dn0 = done_cnt;
      bus.start = 1'b1; bus.is_pos = 1'b1; bus.is_train = 1'b1; bus.post_spike_cnt = 7'd7;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c < 50; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_we",      {31'd0, bus.sram_we}, 0);
      chk("midrst_re",      {31'd0, bus.sram_re}, 0);
      chk("midrst_busy",    {31'd0, bus.busy}, 0);
      chk("midrst_state",   {30'd0, dbg0}, 0);
      chk("midrst_pending", exp_q.size(), NSYN - 48);
      exp_q.delete();
      repeat (5) @(negedge clk);
      chk("midrst_no_done", done_cnt - dn0, 0);
      chk("midrst_sat",     {16'd0, bus.sat_cnt}, 0);
      fill_rand();
      run(1'b0, 1'b1, int'($urandom_range(0, 127)), 1'b0, -1);

      // single synapse, no learning-rate shift
      bus1.lut_we = 1'b1; bus1.lut_sel = 1'b1; bus1.lut_addr = 5'd31; bus1.lut_data = 8'hFF;
      @(negedge clk);
      bus1.lut_sel = 1'b0; bus1.lut_addr = 5'd0; bus1.lut_data = 8'h10;
      @(negedge clk);
      bus1.lut_we = 1'b0;
      run1(0, 31, 1'b1, 127, 255);
      run1(-100, 1, 1'b0, 0, 16);
      run1(120, 31, 1'b1, 31, 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
